// File: rtl/ifu_fetch.sv
// ifu_fetch: single-cycle instruction fetch unit with a 1024-word instruction
// memory at 0x0000_3000, next-PC selection and a two-state RUN/HALT FSM.
// Optional feature macro IFU_JR_EN: when defined, npc_sel=10 selects rs_data
// (jump-register); when undefined, npc_sel=10 falls back to pc + 4.
// The instruction memory has no write port; its contents are loaded from
// outside the design before the core runs.
module ifu_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  npc_sel,
  input  logic        stall,
  input  logic [31:0] rs_data,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] icount
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] SYSCALL  = 32'h0000_000C;
  localparam logic [19:0] IM_PAGE  = 20'h0_0003;

  logic [31:0] imem [0:1023];

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] icount_q, icount_d;
  logic        fault_q, fault_d;

  logic [31:0] npc;
  logic [31:0] br_offset;
  logic [31:0] icount_inc;
  logic        pc_in_range;
  logic        npc_bad;

`ifndef IFU_JR_EN
  logic unused_rs_data;
  assign unused_rs_data = ^rs_data;
`endif

  // Combinational instruction read; zero outside the window or while halted.
  always_comb begin
    pc_in_range = (pc_q[31:12] == IM_PAGE);
    instr       = '0;
    if ((state_q == RUN) && pc_in_range) begin
      instr = imem[pc_q[11:2]];
    end
  end

  // Next-PC selection and target legality check.
  always_comb begin
    pc_plus4  = pc_q + 32'd4;
    br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};
    case (npc_sel)
      2'b01:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      2'b11:   npc = pc_plus4 + br_offset;
`ifdef IFU_JR_EN
      2'b10:   npc = rs_data;
`else
      2'b10:   npc = pc_plus4;
`endif
      default: npc = pc_plus4;
    endcase
    npc_bad = (npc[31:12] != IM_PAGE) || (npc[1:0] != 2'b00);
  end

  // Next-state logic; syscall is tested before the bad-target check so it wins.
  always_comb begin
    icount_inc = (&icount_q) ? icount_q : icount_q + 32'd1;
    state_d    = state_q;
    pc_d       = pc_q;
    icount_d   = icount_q;
    fault_d    = fault_q;
    if ((state_q == RUN) && !stall) begin
      if (instr == SYSCALL) begin
        state_d  = HALT;
        icount_d = icount_inc;
      end else if (npc_bad) begin
        state_d = HALT;
        fault_d = 1'b1;
      end else begin
        pc_d     = npc;
        icount_d = icount_inc;
      end
    end
  end

  // FSM state and architectural registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      pc_q     <= PC_RESET;
      icount_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      icount_q <= icount_d;
      fault_q  <= fault_d;
    end
  end

  assign pc     = pc_q;
  assign halted = (state_q == HALT);
  assign fault  = fault_q;
  assign icount = icount_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: table-driven vectors plus hand sequences for
// syscall halt, bad-target fault, syscall-vs-fault priority and async reset.
module tb_ifu_fetch;

  logic        clk;
  logic        rst;
  logic [1:0]  npc_sel;
  logic        stall;
  logic [31:0] rs_data;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] icount;

  int checks   = 0;
  int failures = 0;

  ifu_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .npc_sel  (npc_sel),
    .stall    (stall),
    .rs_data  (rs_data),
    .instr    (instr),
    .pc       (pc),
    .pc_plus4 (pc_plus4),
    .halted   (halted),
    .fault    (fault),
    .icount   (icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        stl;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic [31:0] e_ic;
    logic        e_halt;
    logic        e_fault;
    logic [31:0] e_instr;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ic,
                           input logic e_h, input logic e_f, input logic [31:0] e_ins);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
    chk({tag, ".icount"}, icount, e_ic);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, e_h});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, e_f});
    chk({tag, ".instr"}, instr, e_ins);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) dut.imem[i] = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b0;
    npc_sel = 2'b00;
    stall   = 1'b0;
    rs_data = 32'h0;

    // Program for the vector table.
    clear_mem();
    dut.imem[0]  = 32'h0000_0001;
    dut.imem[1]  = 32'h0800_0C10;
    dut.imem[2]  = 32'h0000_0002;
    dut.imem[3]  = 32'h0000_0003;
    dut.imem[4]  = 32'h1000_FFFC;
    dut.imem[16] = 32'h0000_0004;

    vecs[0]  = '{2'b00, 1'b0, 32'h0, 32'h3004, 32'd1, 1'b0, 1'b0, 32'h0800_0C10};
    vecs[1]  = '{2'b00, 1'b0, 32'h0, 32'h3008, 32'd2, 1'b0, 1'b0, 32'h0000_0002};
    vecs[2]  = '{2'b00, 1'b0, 32'h0, 32'h300C, 32'd3, 1'b0, 1'b0, 32'h0000_0003};
    vecs[3]  = '{2'b00, 1'b0, 32'h0, 32'h3010, 32'd4, 1'b0, 1'b0, 32'h1000_FFFC};
    vecs[4]  = '{2'b11, 1'b1, 32'h0, 32'h3010, 32'd4, 1'b0, 1'b0, 32'h1000_FFFC};
    vecs[5]  = '{2'b11, 1'b1, 32'h0, 32'h3010, 32'd4, 1'b0, 1'b0, 32'h1000_FFFC};
    vecs[6]  = '{2'b11, 1'b1, 32'h0, 32'h3010, 32'd4, 1'b0, 1'b0, 32'h1000_FFFC};
    vecs[7]  = '{2'b11, 1'b0, 32'h0, 32'h3004, 32'd5, 1'b0, 1'b0, 32'h0800_0C10};
    vecs[8]  = '{2'b01, 1'b0, 32'h0, 32'h3040, 32'd6, 1'b0, 1'b0, 32'h0000_0004};
`ifdef IFU_JR_EN
    vecs[9]  = '{2'b10, 1'b0, 32'h0000_3100, 32'h3100, 32'd7, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{2'b00, 1'b0, 32'h0, 32'h3104, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{2'b10, 1'b0, 32'h0000_3002, 32'h3104, 32'd8, 1'b1, 1'b1, 32'h0};
    vecs[12] = '{2'b00, 1'b0, 32'h0, 32'h3104, 32'd8, 1'b1, 1'b1, 32'h0};
`else
    vecs[9]  = '{2'b10, 1'b0, 32'h0000_3100, 32'h3044, 32'd7, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{2'b00, 1'b0, 32'h0, 32'h3048, 32'd8, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{2'b10, 1'b0, 32'h0000_3002, 32'h304C, 32'd9, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{2'b00, 1'b0, 32'h0, 32'h3050, 32'd10, 1'b0, 1'b0, 32'h0};
`endif

    #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset", 32'h3000, 32'd0, 1'b0, 1'b0, 32'h0000_0001);

    for (int v = 0; v < 13; v++) begin
      npc_sel = vecs[v].sel;
      stall   = vecs[v].stl;
      rs_data = vecs[v].rs;
      step();
      check_all($sformatf("vec%0d", v), vecs[v].e_pc, vecs[v].e_ic,
                vecs[v].e_halt, vecs[v].e_fault, vecs[v].e_instr);
    end

    // Syscall at 0x3008 halts without fault and holds until reset.
    npc_sel = 2'b00; stall = 1'b0; rs_data = 32'h0;
    clear_mem();
    dut.imem[0] = 32'h0000_0005;
    dut.imem[1] = 32'h0000_0006;
    dut.imem[2] = 32'h0000_000C;
    do_reset();
    step();
    step();
    check_all("sys_pre", 32'h3008, 32'd2, 1'b0, 1'b0, 32'h0000_000C);
    step();
    check_all("sys_halt", 32'h3008, 32'd3, 1'b1, 1'b0, 32'h0);
    npc_sel = 2'b01;
    step();
    step();
    check_all("sys_hold", 32'h3008, 32'd3, 1'b1, 1'b0, 32'h0);

    // Syscall at the last word: next pc 0x4000 is out of range, syscall wins.
    clear_mem();
    dut.imem[0]    = 32'h0800_0FFF;
    dut.imem[1023] = 32'h0000_000C;
    npc_sel = 2'b01;
    do_reset();
    step();
    check_all("edge_jmp", 32'h3FFC, 32'd1, 1'b0, 1'b0, 32'h0000_000C);
    npc_sel = 2'b00;
    step();
    check_all("sys_vs_bad", 32'h3FFC, 32'd2, 1'b1, 1'b0, 32'h0);

    // Sequential past the last word faults; then async reset out of HALT.
    dut.imem[1023] = 32'h0000_0007;
    npc_sel = 2'b01;
    do_reset();
    step();
    check_all("edge_jmp2", 32'h3FFC, 32'd1, 1'b0, 1'b0, 32'h0000_0007);
    npc_sel = 2'b00;
    step();
    check_all("oor_fault", 32'h3FFC, 32'd1, 1'b1, 1'b1, 32'h0);
    step();
    check_all("fault_hold", 32'h3FFC, 32'd1, 1'b1, 1'b1, 32'h0);
    #2 rst = 1'b1;
    #1;
    check_all("async_rst", 32'h3000, 32'd0, 1'b0, 1'b0, 32'h0800_0FFF);
    rst = 1'b0;
    step();
    check_all("post_rst", 32'h3004, 32'd1, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 npc_sel  input  2  next-PC select from the control unit: 00 sequential, 01 jump, 11 taken branch, 10 jump-register.
REQ-005 stall  input  1  hold request; PC frozen while high.
REQ-006 rs_data  input  32  register-file rs value, used as the jump-register target.
REQ-007 instr  output  32  instruction at the current PC (combinational read).
REQ-008 pc  output  32  current PC register.
REQ-009 pc_plus4  output  32  pc + 4, wrapping modulo 2^32.
REQ-010 halted  output  1  high while the FSM is in HALT.
REQ-011 fault  output  1  sticky flag: halt caused by an out-of-range or misaligned target.
REQ-012 icount  output  32  count of PC advances (retired fetches).

Function
REQ-013 The instruction memory SHALL be 1024 x 32-bit words, base 0x0000_3000, word index (pc - 0x3000)[11:2], loaded only by the testbench/initial file.
REQ-014 The address range SHALL be 0x0000_3000..0x0000_3FFC; instr SHALL read 0x0000_0000 when pc is outside it.
REQ-015 npc for 00 SHALL be pc_plus4.
REQ-016 npc for 01 SHALL be {pc_plus4[31:28], instr[25:0], 2'b00}.
REQ-017 npc for 11 SHALL be pc_plus4 + (sign_ext(instr[15:0]) << 2), with 32-bit wrap.
REQ-018 npc for 10 SHALL follow the Configuration section.
REQ-019 The FSM SHALL have exactly two states: RUN and HALT.
REQ-020 In RUN with stall=0, each rising edge SHALL load pc <= npc and increment icount.
REQ-021 In RUN with stall=1, pc and icount SHALL hold, and halt conditions SHALL NOT be evaluated.
REQ-022 RUN->HALT SHALL occur when instr == 0x0000_000C (syscall) with stall=0; pc SHALL keep the syscall address, icount SHALL still increment, and fault SHALL stay 0.
REQ-023 RUN->HALT SHALL occur when npc is outside the address range or npc[1:0] != 0, with stall=0; pc SHALL hold, icount SHALL NOT increment, and fault SHALL be set to 1.
REQ-024 If a syscall and a bad npc occur in the same cycle, the syscall rule SHALL win and fault SHALL stay 0.
REQ-025 In HALT, pc, icount and fault SHALL hold; instr SHALL be forced to 0x0000_0000; only rst SHALL leave HALT.
REQ-026 icount SHALL saturate at 0xFFFF_FFFF.
REQ-027 Latency: a new npc_sel SHALL be visible on pc one edge later; there SHALL be no other pipeline registers.

Reset
REQ-028 On rst=1, asynchronously: pc=0x0000_3000, state=RUN, halted=0, fault=0, icount=0.
REQ-029 Reset asserted mid-stall or mid-HALT SHALL produce the same values as REQ-028; the first fetch after release SHALL be from 0x0000_3000.

Configuration
REQ-030 Macro IFU_JR_EN defined: npc for 10 SHALL be rs_data, subject to the range and alignment checks of REQ-023.
REQ-031 Macro IFU_JR_EN undefined: npc_sel=10 SHALL behave as 00 (pc_plus4), and rs_data SHALL be ignored.

Verification
REQ-032 Reset, then IM of sequential non-syscall words with npc_sel=00 for 4 cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C, 0x3010; icount = 4.
REQ-033 At pc=0x3004, instr=0x0800_0C10 with npc_sel=01 -> next pc = 0x0000_3040.
REQ-034 At pc=0x3010, instr[15:0]=0xFFFC with npc_sel=11 -> next pc = 0x0000_3004; with stall=1 held 3 cycles first -> pc stays 0x3010 and icount unchanged for those cycles.
REQ-035 Syscall 0x0000_000C at 0x3008 -> halted=1, pc=0x3008, fault=0, instr reads 0; stays there until rst.
REQ-036 IFU_JR_EN defined, npc_sel=10, rs_data=0x0000_3002 -> halted=1, fault=1, pc unchanged; with rs_data=0x0000_3100 -> pc = 0x3100. IFU_JR_EN undefined, same stimulus -> pc = pc + 4.
REQ-037 Assert rst asynchronously while in HALT with fault=1 -> pc=0x3000, fault=0, halted=0, icount=0, before the next clock edge.
